// File: rtl/input_port_buffer.sv
// input_port_buffer: router input-port FIFO with a registered output stage.
// A flit pushed into an empty buffer appears on data_out two edges later:
// one edge writes storage, the next pops it into the output register.
// Optional build macro INBUF_OVF_DETECT_EN adds a sticky overflow flag that
// records any push attempted while the FIFO is full.
module input_port_buffer #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] data_in,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  input  logic              rd_en,
  input  logic              en,
  output logic [FLIT_W-1:0] data_out,
  output logic              valid,
  output logic              ovf
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              push, pop;

  // Flags come from the registered count only, so the upstream flow-control
  // logic never sees a combinational path through this block.
  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);

  // A push is judged against the full flag at the start of the cycle, so a
  // same-cycle pop does not make room. Pops are gated by the output enable.
  assign push = wr_en && !full;
  assign pop  = en && rd_en && !empty;

  // Storage write; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // Pointers and occupancy counter; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output register: loads the head flit on a pop, drops valid on an enabled
  // cycle without a pop, and freezes entirely while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      valid    <= 1'b0;
    end else if (en) begin
      if (pop) begin
        data_out <= mem[rd_ptr];
        valid    <= 1'b1;
      end else begin
        valid    <= 1'b0;
      end
    end
  end

`ifdef INBUF_OVF_DETECT_EN
  // Sticky overflow: set on any rejected push, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ovf <= 1'b0;
    else if (wr_en && full)  ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer (DEPTH=4, FLIT_W=32).
module tb_input_port_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic        wr_en, rd_en, en;
  logic        full, empty, valid, ovf;
  logic [31:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef INBUF_OVF_DETECT_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  input_port_buffer #(.FLIT_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en),
    .full(full), .empty(empty), .rd_en(rd_en), .en(en),
    .data_out(data_out), .valid(valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [31:0] d, input logic r, input logic e);
    wr_en = w; data_in = d; rd_en = r; en = e;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    #3;
    chk("rst_valid", valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_count", dut.count, 0);
    tick();
    rst_n = 1'b1;

    // Three-flit burst with rd_en following !empty
    drive(1, 32'hA1, 0, 1); tick();
    chk("b_valid_e0", valid, 0);
    chk("b_empty_e0", empty, 0);
    drive(1, 32'hA2, 1, 1); tick();
    chk("b_valid_e1", valid, 1);
    chk("b_d_a1", data_out, 32'hA1);
    drive(1, 32'hA3, 1, 1); tick();
    chk("b_d_a2", data_out, 32'hA2);
    drive(0, 0, 1, 1); tick();
    chk("b_d_a3", data_out, 32'hA3);
    chk("b_valid_a3", valid, 1);
    chk("b_empty_end", empty, 1);
    drive(0, 0, 0, 1); tick();
    chk("b_valid_idle", valid, 0);
    chk("b_d_hold", data_out, 32'hA3);

    // Fill with en=0, overflow push, then drain
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h10 + i, 0, 0); tick();
    end
    chk("f_full", full, 1);
    chk("f_count4", dut.count, 4);
    drive(1, 32'h14, 0, 0); tick();
    chk("f_count_rej", dut.count, 4);
    chk("f_ovf", ovf, OVF_EXP);
    drive(0, 0, 1, 0); tick();
    chk("f_en0_nopop", dut.count, 4);
    chk("f_en0_valid", valid, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 1); tick();
      chk("f_drain_d", data_out, 32'h10 + i);
      chk("f_drain_v", valid, 1);
    end
    chk("f_empty", empty, 1);
    drive(0, 0, 0, 1); tick();
    chk("f_valid_end", valid, 0);

    // Full buffer: push and pop in same cycle, push rejected
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h20 + i, 0, 0); tick();
    end
    drive(1, 32'h55, 1, 1); tick();
    chk("fp_count3", dut.count, 3);
    chk("fp_d20", data_out, 32'h20);
    for (int i = 1; i < 4; i++) begin
      drive(0, 0, 1, 1); tick();
      chk("fp_drain_d", data_out, 32'h20 + i);
    end
    chk("fp_empty", empty, 1);
    drive(0, 0, 1, 1); tick();
    chk("fp_rd_empty_v", valid, 0);
    chk("fp_rd_empty_c", dut.count, 0);

    // Streaming across pointer wrap
    drive(1, 32'h30, 0, 1); tick();
    for (int i = 1; i < 10; i++) begin
      drive(1, 32'h30 + i, 1, 1); tick();
      chk("s_d", data_out, 32'h30 + i - 1);
      chk("s_v", valid, 1);
      chk("s_count", dut.count, 1);
    end
    drive(0, 0, 1, 1); tick();
    chk("s_d_last", data_out, 32'h39);
    chk("s_empty", empty, 1);
    drive(0, 0, 0, 1); tick();

    // Output stall with en=0 while valid
    drive(1, 32'h77, 0, 1); tick();
    drive(1, 32'h78, 1, 1); tick();
    chk("st_d77", data_out, 32'h77);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0); tick();
      chk("st_hold_d", data_out, 32'h77);
      chk("st_hold_v", valid, 1);
      chk("st_hold_c", dut.count, 1);
    end
    drive(0, 0, 1, 1); tick();
    chk("st_resume", data_out, 32'h78);
    drive(0, 0, 0, 1); tick();
    chk("st_idle_v", valid, 0);

    // Asynchronous reset mid-transfer
    drive(1, 32'h40, 0, 1); tick();
    drive(1, 32'h41, 1, 1); tick();
    drive(1, 32'h42, 0, 0); tick();
    drive(1, 32'h43, 0, 0); tick();
    drive(0, 0, 0, 0);
    chk("r_pre_count", dut.count, 3);
    chk("r_pre_valid", valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_valid", valid, 0);
    chk("r_empty", empty, 1);
    chk("r_ovf", ovf, 0);
    chk("r_dout", data_out, 0);
    rst_n = 1'b1;
    drive(1, 32'h99, 0, 1); tick();
    chk("r_post_v0", valid, 0);
    drive(0, 0, 1, 1); tick();
    chk("r_post_d", data_out, 32'h99);
    chk("r_post_v", valid, 1);
    chk("r_post_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
